// File: rtl/prog_load_dump_ctrl.sv
// Bring-up controller: streams a program into instruction memory and runs the CPU under a watchdog.
// It then dumps data memory and the register file as a tagged valid/ready stream.
module prog_load_dump_ctrl #(
    parameter int                 INSTR_W    = 16,
    parameter int                 DATA_W     = 16,
    parameter int                 IMEM_DEPTH = 256,
    parameter int                 DMEM_DUMP  = 10,
    parameter int                 NREGS      = 16,
    parameter int                 TIMEOUT    = 5000,
    parameter logic [INSTR_W-1:0] HALT_WORD  = INSTR_W'(16'hFFFF)
) (
    input  logic                          CLK,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [INSTR_W-1:0]            ld_data,
    input  logic                          ld_last,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    output logic [INSTR_W-1:0]            imem_wdata,
    output logic                          cpu_rst,
    input  logic                          do_halt,
    output logic [7:0]                    dmem_raddr,
    input  logic [DATA_W-1:0]             dmem_rdata,
    output logic [$clog2(NREGS)-1:0]      reg_raddr,
    input  logic [DATA_W-1:0]             reg_rdata,
    output logic                          dump_valid,
    input  logic                          dump_ready,
    output logic [DATA_W-1:0]             dump_data,
    output logic                          dump_is_reg,
    output logic [7:0]                    dump_idx,
    output logic                          done,
    output logic                          timeout,
    output logic                          load_ovf,
    output logic [31:0]                   cycle_count
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int RW = $clog2(NREGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PAD,
        S_RUN,
        S_DUMP_MEM,
        S_DUMP_REG,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [AW-1:0]       load_addr_reg, load_addr_next;
    logic [31:0]         cycle_count_reg, cycle_count_next;
    logic                timeout_reg, timeout_next;
    logic                load_ovf_reg, load_ovf_next;
    logic                done_reg, done_next;
    logic                halt_q_reg;
    logic [7:0]          rd_idx_reg, rd_idx_next;
    logic                fetch_reg, fetch_next;
    logic                fetch_is_reg_reg, fetch_is_reg_next;
    logic [7:0]          fetch_idx_reg, fetch_idx_next;
    logic                issued_all_reg, issued_all_next;
    logic                dump_valid_reg, dump_valid_next;
    logic [DATA_W-1:0]   dump_data_reg, dump_data_next;
    logic                dump_is_reg_reg, dump_is_reg_next;
    logic [7:0]          dump_idx_reg, dump_idx_next;

    logic halt_fall;
    logic handshake;
    logic can_issue;

    assign halt_fall = halt_q_reg & ~do_halt;
    assign handshake = dump_valid_reg & dump_ready;
    // A new read may go out only when its data can be captured into a free output slot next cycle.
    assign can_issue = !fetch_reg && (!dump_valid_reg || dump_ready) && !issued_all_reg;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            load_addr_reg    <= '0;
            cycle_count_reg  <= '0;
            timeout_reg      <= 1'b0;
            load_ovf_reg     <= 1'b0;
            done_reg         <= 1'b0;
            halt_q_reg       <= 1'b0;
            rd_idx_reg       <= '0;
            fetch_reg        <= 1'b0;
            fetch_is_reg_reg <= 1'b0;
            fetch_idx_reg    <= '0;
            issued_all_reg   <= 1'b0;
            dump_valid_reg   <= 1'b0;
            dump_data_reg    <= '0;
            dump_is_reg_reg  <= 1'b0;
            dump_idx_reg     <= '0;
        end else begin
            state_reg        <= state_next;
            load_addr_reg    <= load_addr_next;
            cycle_count_reg  <= cycle_count_next;
            timeout_reg      <= timeout_next;
            load_ovf_reg     <= load_ovf_next;
            done_reg         <= done_next;
            halt_q_reg       <= do_halt;
            rd_idx_reg       <= rd_idx_next;
            fetch_reg        <= fetch_next;
            fetch_is_reg_reg <= fetch_is_reg_next;
            fetch_idx_reg    <= fetch_idx_next;
            issued_all_reg   <= issued_all_next;
            dump_valid_reg   <= dump_valid_next;
            dump_data_reg    <= dump_data_next;
            dump_is_reg_reg  <= dump_is_reg_next;
            dump_idx_reg     <= dump_idx_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        load_addr_next    = load_addr_reg;
        cycle_count_next  = cycle_count_reg;
        timeout_next      = timeout_reg;
        load_ovf_next     = load_ovf_reg;
        done_next         = done_reg;
        rd_idx_next       = rd_idx_reg;
        fetch_next        = 1'b0;
        fetch_is_reg_next = fetch_is_reg_reg;
        fetch_idx_next    = fetch_idx_reg;
        issued_all_next   = issued_all_reg;
        dump_valid_next   = dump_valid_reg;
        dump_data_next    = dump_data_reg;
        dump_is_reg_next  = dump_is_reg_reg;
        dump_idx_next     = dump_idx_reg;
        ld_ready          = 1'b0;
        imem_we           = 1'b0;
        imem_wdata        = ld_data;
        cpu_rst           = 1'b1;
        dmem_raddr        = '0;
        reg_raddr         = '0;

        // Read data issued last cycle lands in the output slot, which is empty by construction.
        if (fetch_reg) begin
            dump_valid_next  = 1'b1;
            dump_data_next   = fetch_is_reg_reg ? reg_rdata : dmem_rdata;
            dump_is_reg_next = fetch_is_reg_reg;
            dump_idx_next    = fetch_idx_reg;
        end else if (handshake) begin
            dump_valid_next = 1'b0;
        end

        case (state_reg)
            S_IDLE, S_DONE: begin
                cpu_rst = (state_reg == S_IDLE);
                if (start) begin
                    state_next       = S_LOAD;
                    load_addr_next   = '0;
                    cycle_count_next = '0;
                    timeout_next     = 1'b0;
                    load_ovf_next    = 1'b0;
                    done_next        = 1'b0;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    imem_we        = 1'b1;
                    load_addr_next = load_addr_reg + AW'(1);
                    if (ld_last) begin
                        // No room for a pad word at the top address, so run directly.
                        if (ld_data == HALT_WORD || load_addr_reg == AW'(IMEM_DEPTH - 1))
                            state_next = S_RUN;
                        else
                            state_next = S_PAD;
                    end else if (load_addr_reg == AW'(IMEM_DEPTH - 1)) begin
                        load_ovf_next = 1'b1;
                        state_next    = S_RUN;
                    end
                end
            end
            S_PAD: begin
                imem_we    = 1'b1;
                imem_wdata = HALT_WORD;
                state_next = S_RUN;
            end
            S_RUN: begin
                cpu_rst = 1'b0;
                if (halt_fall || cycle_count_reg == 32'(TIMEOUT - 1)) begin
                    timeout_next    = !halt_fall;
                    rd_idx_next     = '0;
                    issued_all_next = 1'b0;
                    state_next      = (DMEM_DUMP == 0) ? S_DUMP_REG : S_DUMP_MEM;
                end else if (cycle_count_reg != '1) begin
                    cycle_count_next = cycle_count_reg + 32'd1;
                end
            end
            S_DUMP_MEM: begin
                cpu_rst    = 1'b0;
                dmem_raddr = rd_idx_reg;
                if (can_issue) begin
                    fetch_next        = 1'b1;
                    fetch_is_reg_next = 1'b0;
                    fetch_idx_next    = rd_idx_reg;
                    if (rd_idx_reg == 8'(DMEM_DUMP - 1)) begin
                        rd_idx_next = '0;
                        state_next  = S_DUMP_REG;
                    end else begin
                        rd_idx_next = rd_idx_reg + 8'd1;
                    end
                end
            end
            S_DUMP_REG: begin
                cpu_rst   = 1'b0;
                reg_raddr = rd_idx_reg[RW-1:0];
                if (can_issue) begin
                    fetch_next        = 1'b1;
                    fetch_is_reg_next = 1'b1;
                    fetch_idx_next    = rd_idx_reg;
                    if (rd_idx_reg == 8'(NREGS - 1))
                        issued_all_next = 1'b1;
                    else
                        rd_idx_next = rd_idx_reg + 8'd1;
                end
                if (issued_all_reg && !fetch_reg && handshake) begin
                    done_next  = 1'b1;
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign imem_addr   = load_addr_reg;
    assign dump_valid  = dump_valid_reg;
    assign dump_data   = dump_data_reg;
    assign dump_is_reg = dump_is_reg_reg;
    assign dump_idx    = dump_idx_reg;
    assign done        = done_reg;
    assign timeout     = timeout_reg;
    assign load_ovf    = load_ovf_reg;
    assign cycle_count = cycle_count_reg;

endmodule
